// File: rtl/mem_port_arbiter.sv
// Two-requester front end for a single-outstanding memory port: arbitrates,
// captures the winning request, tracks the response with a timeout and drains late responses.
module mem_port_arbiter #(
   parameter int unsigned TIMEOUT    = 255,
   parameter bit          FIXED_PRIO = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        p0_valid,
   input  logic [31:0] p0_addr,
   input  logic [31:0] p0_wdata,
   input  logic [3:0]  p0_wstrb,
   output logic        p0_ready,
   output logic [31:0] p0_rdata,
   output logic        p0_err,
   input  logic        p1_valid,
   input  logic [31:0] p1_addr,
   input  logic [31:0] p1_wdata,
   input  logic [3:0]  p1_wstrb,
   output logic        p1_ready,
   output logic [31:0] p1_rdata,
   output logic        p1_err,
   output logic        mem_req,
   input  logic        mem_gnt,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_strb,
   output logic        mem_we,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        proto_err
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_RESP,
      ST_DRAIN
   } state_t;

   localparam logic [16:0] TMO_LIMIT = 17'(TIMEOUT);

   state_t      state_reg;
   logic        last_grant_reg;
   logic        port_reg;
   logic [15:0] cnt_reg;
   logic        drain_reg;
   logic        proto_err_reg;
   logic        req_reg;
   logic        we_reg;
   logic [31:0] addr_reg;
   logic [31:0] wdata_reg;
   logic [3:0]  strb_reg;
   logic [1:0]  ready_reg;
   logic [1:0]  err_reg;
   logic [31:0] rdata_reg [2];

   logic [1:0]  valid;
   logic [31:0] addr_in  [2];
   logic [31:0] wdata_in [2];
   logic [3:0]  wstrb_in [2];
   logic        winner;
   logic        timeout_hit;

   assign valid       = {p1_valid, p0_valid};
   assign addr_in[0]  = p0_addr;
   assign addr_in[1]  = p1_addr;
   assign wdata_in[0] = p0_wdata;
   assign wdata_in[1] = p1_wdata;
   assign wstrb_in[0] = p0_wstrb;
   assign wstrb_in[1] = p1_wstrb;

   // On a conflict round-robin favours the port that did not win last time.
   always_comb begin
      winner = valid[1];
      if (valid[0] && valid[1]) begin
         winner = FIXED_PRIO ? 1'b0 : ~last_grant_reg;
      end
   end

   // Fires in the WAIT cycle whose increment would bring the counter to TIMEOUT.
   assign timeout_hit = (({1'b0, cnt_reg} + 17'd1) >= TMO_LIMIT);

   always_ff @(posedge clk) begin
      ready_reg    <= 2'b00;
      err_reg      <= 2'b00;
      rdata_reg[0] <= '0;
      rdata_reg[1] <= '0;
      if (rst) begin
         state_reg      <= ST_IDLE;
         last_grant_reg <= 1'b1;
         port_reg       <= 1'b0;
         cnt_reg        <= '0;
         drain_reg      <= 1'b0;
         proto_err_reg  <= 1'b0;
         req_reg        <= 1'b0;
         we_reg         <= 1'b0;
         addr_reg       <= '0;
         wdata_reg      <= '0;
         strb_reg       <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (|valid) begin
                  port_reg       <= winner;
                  last_grant_reg <= winner;
                  addr_reg       <= addr_in[winner];
                  wdata_reg      <= wdata_in[winner];
                  strb_reg       <= (wstrb_in[winner] == 4'h0) ? 4'hF : wstrb_in[winner];
                  we_reg         <= |wstrb_in[winner];
                  req_reg        <= 1'b1;
                  state_reg      <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (mem_gnt) begin
                  req_reg   <= 1'b0;
                  cnt_reg   <= '0;
                  state_reg <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (mem_rvalid) begin
                  ready_reg[port_reg] <= 1'b1;
                  rdata_reg[port_reg] <= mem_rdata;
                  err_reg[port_reg]   <= 1'b0;
                  state_reg           <= ST_RESP;
               end else begin
                  if (cnt_reg != 16'hFFFF) begin
                     cnt_reg <= cnt_reg + 16'd1;
                  end
                  if (timeout_hit) begin
                     ready_reg[port_reg] <= 1'b1;
                     err_reg[port_reg]   <= 1'b1;
                     drain_reg           <= 1'b1;
                     state_reg           <= ST_RESP;
                  end
               end
            end
            ST_RESP: begin
               state_reg <= drain_reg ? ST_DRAIN : ST_IDLE;
            end
            ST_DRAIN: begin
               if (mem_rvalid) begin
                  drain_reg <= 1'b0;
                  state_reg <= ST_IDLE;
               end
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase

         if (mem_rvalid && (state_reg == ST_IDLE || state_reg == ST_REQ || state_reg == ST_RESP)) begin
            proto_err_reg <= 1'b1;
         end
      end
   end

   assign mem_req   = req_reg;
   assign mem_addr  = addr_reg;
   assign mem_wdata = wdata_reg;
   assign mem_strb  = strb_reg;
   assign mem_we    = we_reg;
   assign proto_err = proto_err_reg;
   assign p0_ready  = ready_reg[0];
   assign p1_ready  = ready_reg[1];
   assign p0_err    = err_reg[0];
   assign p1_err    = err_reg[1];
   assign p0_rdata  = rdata_reg[0];
   assign p1_rdata  = rdata_reg[1];

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255, meaning cycles waited in WAIT for mem_rvalid before an error response (legal range 1..65535).
REQ-002 Parameter FIXED_PRIO, default 0, meaning 0 = round-robin arbitration and 1 = port 0 always wins a conflict.
REQ-003 clk  input  1  single clock for the block; all logic SHALL be rising-edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 pN_valid  input  1  requester N (N=0,1) request pending; held with fields stable until pN_ready.
REQ-006 pN_addr  input  32  requester N byte address; passed through unmodified.
REQ-007 pN_wdata  input  32  requester N write data.
REQ-008 pN_wstrb  input  4  requester N byte strobes; 0 = read, nonzero = write.
REQ-009 pN_ready  output  1  one-cycle completion pulse to requester N.
REQ-010 pN_rdata  output  32  response data, valid only while pN_ready is high.
REQ-011 pN_err  output  1  response error flag, valid only while pN_ready is high.
REQ-012 mem_req  output  1  memory request; held until mem_gnt.
REQ-013 mem_gnt  input  1  memory accepts the request in the cycle both mem_req and mem_gnt are high.
REQ-014 mem_addr, mem_wdata  output  32 each  captured request address and data.
REQ-015 mem_strb  output  4  captured pN_wstrb for writes; 4'hF for reads.
REQ-016 mem_we  output  1  high when the captured pN_wstrb is nonzero.
REQ-017 mem_rvalid  input  1  memory response strobe, one per granted request, reads and writes.
REQ-018 mem_rdata  input  32  memory read data, valid with mem_rvalid.
REQ-019 proto_err  output  1  sticky flag set by an unexpected mem_rvalid.

Function
REQ-020 FSM states SHALL be IDLE, REQ, WAIT, RESP, DRAIN; one transaction outstanding at most.
REQ-021 IDLE: if any pN_valid, select a winner, capture its addr/wdata/wstrb and its port index, and go to REQ; otherwise stay in IDLE.
REQ-022 Conflict (both valid) with FIXED_PRIO=0: the winner SHALL be the port not granted last; with FIXED_PRIO=1: the winner SHALL be port 0.
REQ-023 last_grant SHALL update only on winner selection; a single valid requester always wins.
REQ-024 REQ: mem_req=1 with outputs driven from captured registers, stable until mem_gnt; on mem_gnt go to WAIT and clear the timeout counter; no timeout in REQ.
REQ-025 Latency: pN_valid sampled in IDLE at cycle t -> mem_req high at t+1; mem_gnt at t+1 with mem_rvalid at t+2 -> pN_ready at t+3.
REQ-026 WAIT: on mem_rvalid, register mem_rdata, set err=0 and go to RESP; otherwise increment the counter.
REQ-027 WAIT: when the counter reaches TIMEOUT without mem_rvalid, register rdata=0, set err=1 and go to RESP while marking a pending drain.
REQ-028 mem_rvalid in the same cycle the counter reaches TIMEOUT SHALL count as success (err=0, no drain).
REQ-029 RESP: pulse pN_ready of the captured port only, with registered rdata/err; the other port's ready stays 0; next state is DRAIN if a drain is pending, else IDLE.
REQ-030 DRAIN: discard mem_rvalid/mem_rdata, go to IDLE on mem_rvalid; new requests wait.
REQ-031 pN_rdata/pN_err SHALL be 0 whenever pN_ready is 0.
REQ-032 mem_rvalid in IDLE, REQ or RESP SHALL be ignored and SHALL set proto_err, which is cleared only by rst.
REQ-033 Requester fields changing between selection and pN_ready SHALL NOT affect the transaction in flight.
REQ-034 The timeout counter SHALL be 16 bits and SHALL saturate, never wrap.

Reset
REQ-035 While rst is high at a clock edge: state=IDLE, last_grant=1 (port 0 wins the first conflict), counter=0, drain flag=0, proto_err=0.
REQ-036 During and after rst: mem_req, mem_we, pN_ready, pN_err = 0; mem_addr, mem_wdata, mem_strb, pN_rdata = 0.
REQ-037 rst mid-transaction SHALL abandon the transaction with no pN_ready pulse; a late mem_rvalid then sets proto_err.

Verification
REQ-038 p0 read addr 0x8000_0000 at t, mem_gnt at t+1, mem_rvalid with rdata 0xDEAD_BEEF at t+2 -> p0_ready=1, p0_rdata=0xDEAD_BEEF, p0_err=0 at t+3; p1_ready=0.
REQ-039 Both ports valid for 4 back-to-back transactions after reset, FIXED_PRIO=0 -> grant order p0, p1, p0, p1; with FIXED_PRIO=1 -> p0 served until p0_valid drops.
REQ-040 p1 write wstrb=4'b0011 addr 0x10 with mem_gnt held low 5 cycles -> mem_req, mem_addr=0x10, mem_strb=4'b0011, mem_we=1 all stable for 5 cycles, no error.
REQ-041 TIMEOUT=4, mem_rvalid withheld -> p0_ready with p0_err=1 and p0_rdata=0 after 4 WAIT cycles; a p1 request issued next is held off until the late mem_rvalid is drained, then served.
REQ-042 mem_rvalid pulsed in IDLE -> proto_err=1 and stays 1 until rst; no pN_ready pulse.
REQ-043 rst asserted while in WAIT -> all outputs 0 on the next cycle, no pN_ready, state IDLE; mem_rvalid arriving afterwards sets proto_err.
